smi_master: RTL

//  FPGA-side SMI initiator: issues the same !OE/!WE strobed parallel bus cycles the Pi SMI

---
 rtl/smi_master.sv | 137 +++++++++++++
 1 files changed

// File: rtl/smi_master.sv
// SMI bus initiator: sequences SETUP/STROBE/HOLD phases for one read or write
// command at a time and returns captured read data.
module smi_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned SETUP      = 2,
  parameter int unsigned STROBE     = 4,
  parameter int unsigned HOLD       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] smi_addr,
  output logic                  smi_oe_n,
  output logic                  smi_we_n,
  output logic [DATA_WIDTH-1:0] smi_data_out,
  output logic                  smi_data_oe,
  input  logic [DATA_WIDTH-1:0] smi_data_in
);

  localparam int unsigned CNT_W = $clog2(256);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    is_write, is_write_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [DATA_WIDTH-1:0]   dout_nx;
  logic                    doe_nx;
  logic                    oe_n_nx;
  logic                    we_n_nx;
  logic                    rsp_valid_nx;
  logic [DATA_WIDTH-1:0]   rdata_nx;

  assign cmd_ready = (state == S_IDLE) && reset;
  assign busy      = (state != S_IDLE);

  // State and registered bus outputs; reset forces strobes high and releases the data pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      is_write     <= 1'b0;
      smi_addr     <= '0;
      smi_data_out <= '0;
      smi_data_oe  <= 1'b0;
      smi_oe_n     <= 1'b1;
      smi_we_n     <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      is_write     <= is_write_nx;
      smi_addr     <= addr_nx;
      smi_data_out <= dout_nx;
      smi_data_oe  <= doe_nx;
      smi_oe_n     <= oe_n_nx;
      smi_we_n     <= we_n_nx;
      rsp_valid    <= rsp_valid_nx;
      rsp_rdata    <= rdata_nx;
    end
  end

  // Phase sequencing; the down-counter is reloaded with (length-1) on each phase entry.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    is_write_nx  = is_write;
    addr_nx      = smi_addr;
    dout_nx      = smi_data_out;
    doe_nx       = smi_data_oe;
    oe_n_nx      = smi_oe_n;
    we_n_nx      = smi_we_n;
    rsp_valid_nx = 1'b0;
    rdata_nx     = rsp_rdata;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nx    = S_SETUP;
          cnt_nx      = CNT_W'(SETUP - 1);
          is_write_nx = cmd_write;
          addr_nx     = cmd_addr;
          dout_nx     = cmd_wdata;
          doe_nx      = cmd_write;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nx = S_STROBE;
          cnt_nx   = CNT_W'(STROBE - 1);
          we_n_nx  = !is_write;
          oe_n_nx  = is_write;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          state_nx = S_HOLD;
          cnt_nx   = CNT_W'(HOLD - 1);
          we_n_nx  = 1'b1;
          oe_n_nx  = 1'b1;
          if (!is_write) begin
            rsp_valid_nx = 1'b1;
            rdata_nx     = smi_data_in;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nx = S_IDLE;
          doe_nx   = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
